pe_result_packer: RTL and testbench

//   Downstream of matrix_pe. Collects 32-bit results arriving on result/vld_o, which has no

---
 rtl/pe_result_packer.sv | 153 +++++++++++++++
 tb/tb_pe_result_packer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_packer.sv
// pe_result_packer: gathers 32-bit matrix_pe results into LANES-wide lines,
// queues finished lines in a DEPTH-entry FIFO and presents them on a
// valid/ready port with an incrementing line address.
// Optional feature macro: RESULT_RELU_EN (negative results stored as zero).
module pe_result_packer #(
    parameter int unsigned   LANES     = 16,
    parameter int unsigned   DEPTH     = 4,
    parameter int unsigned   AW        = 16,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         result,
    input  logic                vld_o,
    input  logic                flush,
    output logic [LANES*32-1:0] out_data,
    output logic [LANES-1:0]    out_mask,
    output logic [AW-1:0]       out_addr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overflow,
    output logic                busy
);
    localparam int unsigned CW = $clog2(LANES + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = PW + 1;
    localparam int unsigned LW = LANES * 32;

    typedef enum logic {FILL, PEND} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_nxt;
    logic [LANES-1:0][31:0]  lanes_q, lanes_d;
    logic [LANES-1:0]        hmask_q, hmask_d;
    logic                    ovf_q, ovf_d;
    logic [LANES-1:0][31:0]  line_data;
    logic [LANES-1:0]        line_mask;
    logic                    push, pop, full;
    logic [31:0]             res_eff;

    logic [LW-1:0]           data_mem [DEPTH];
    logic [LANES-1:0]        mask_mem [DEPTH];
    logic [PW-1:0]           wptr_q, rptr_q;
    logic [FW-1:0]           count_q;
    logic [AW-1:0]           addr_q;

`ifdef RESULT_RELU_EN
    assign res_eff = result[31] ? 32'h0 : result;
`else
    assign res_eff = result;
`endif

    assign full      = (count_q == FW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

    // Packing and line-close decisions; a held line lives in lanes_q/hmask_q while in PEND
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lanes_d   = lanes_q;
        hmask_d   = hmask_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        cnt_nxt   = cnt_q;
        line_data = lanes_q;
        line_mask = hmask_q;
        unique case (state_q)
            FILL: begin
                for (int i = 0; i < LANES; i++) begin
                    if (vld_o && cnt_q == CW'(i)) lanes_d[i] = res_eff;
                end
                if (vld_o) cnt_nxt = cnt_q + 1'b1;
                for (int i = 0; i < LANES; i++) line_mask[i] = (CW'(i) < cnt_nxt);
                line_data = lanes_d;
                // A result arriving with flush is packed first, so a full line absorbs the flush
                if (cnt_nxt == CW'(LANES) || (flush && cnt_nxt != '0)) begin
                    cnt_d = '0;
                    if (!full) begin
                        push    = 1'b1;
                        lanes_d = '0;
                    end else begin
                        hmask_d = line_mask;
                        state_d = PEND;
                    end
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
            PEND: begin
                if (vld_o) ovf_d = 1'b1;
                if (!full || pop) begin
                    push    = 1'b1;
                    lanes_d = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Packer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            lanes_q <= '0;
            hmask_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
            hmask_q <= hmask_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO pointers, occupancy and output line address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            addr_q  <= BASE_ADDR;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
                addr_q <= addr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO storage; contents are only visible through the valid-gated outputs
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wptr_q] <= line_data;
            mask_mem[wptr_q] <= line_mask;
        end
    end

    assign out_data = out_valid ? data_mem[rptr_q] : '0;
    assign out_mask = out_valid ? mask_mem[rptr_q] : '0;
    assign out_addr = addr_q;
    assign overflow = ovf_q;
    assign busy     = (cnt_q != '0) || (state_q == PEND) || out_valid;
endmodule

// File: tb/tb_pe_result_packer.sv
// Bench for pe_result_packer: directed scenarios plus a randomized run
// checked against a queue-based model of lines, FIFO and address.
module tb_pe_result_packer;
    localparam int LANES = 16;
    localparam int DEPTH = 4;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic [31:0]  result = '0;
    logic         vld_o = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [511:0] out_data, out_data1;
    logic [15:0]  out_mask, out_mask1, out_addr, out_addr1;
    logic         out_valid, out_valid1, overflow, overflow1, busy, busy1;

    always #5 clk = ~clk;

    pe_result_packer #(.LANES(16), .DEPTH(4), .AW(16), .BASE_ADDR(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .result(result), .vld_o(vld_o), .flush(flush),
        .out_data(out_data), .out_mask(out_mask), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .busy(busy));

    pe_result_packer #(.LANES(16), .DEPTH(4), .AW(16), .BASE_ADDR(16'hFFFF)) dut_hi (
        .clk(clk), .rst_n(rst_n), .result(result), .vld_o(vld_o), .flush(flush),
        .out_data(out_data1), .out_mask(out_mask1), .out_addr(out_addr1), .out_valid(out_valid1),
        .out_ready(out_ready), .overflow(overflow1), .busy(busy1));

    int n_vec = 0, n_err = 0;

    // reference model
    logic [31:0]  m_part[$];
    logic [511:0] m_qd[$];
    logic [15:0]  m_qm[$];
    bit           m_pend, m_ovf;
    logic [511:0] m_pd;
    logic [15:0]  m_pm;
    logic [15:0]  m_addr;

    function automatic logic [31:0] relu(input logic [31:0] r);
`ifdef RESULT_RELU_EN
        return r[31] ? 32'h0 : r;
`else
        return r;
`endif
    endfunction

    function automatic void model_step(input bit v, input logic [31:0] r, input bit f, input bit rdy);
        bit pop;
        int sz;
        logic [511:0] d;
        logic [15:0]  mk;
        sz  = m_qd.size();
        pop = rdy && sz != 0;
        if (m_pend) begin
            if (v) m_ovf = 1'b1;
            if (sz < DEPTH || pop) begin
                m_qd.push_back(m_pd);
                m_qm.push_back(m_pm);
                m_pend = 1'b0;
            end
        end else begin
            if (v) m_part.push_back(relu(r));
            if (m_part.size() == LANES || (f && m_part.size() != 0)) begin
                d = '0;
                mk = '0;
                foreach (m_part[i]) begin
                    d[32*i +: 32] = m_part[i];
                    mk[i] = 1'b1;
                end
                m_part.delete();
                if (sz < DEPTH) begin
                    m_qd.push_back(d);
                    m_qm.push_back(mk);
                end else begin
                    m_pend = 1'b1;
                    m_pd = d;
                    m_pm = mk;
                end
            end
        end
        if (pop) begin
            void'(m_qd.pop_front());
            void'(m_qm.pop_front());
            m_addr = m_addr + 16'h1;
        end
    endfunction

    task automatic drive(input bit v, input logic [31:0] r, input bit f, input bit rdy);
        vld_o = v; result = r; flush = f; out_ready = rdy;
        model_step(v, r, f, rdy);
        @(posedge clk);
        #1;
        vld_o = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vld_o = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2;
        m_part.delete(); m_qd.delete(); m_qm.delete();
        m_pend = 1'b0; m_ovf = 1'b0; m_addr = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (out_valid !== 1'b0 || out_mask !== 16'h0 || out_data !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b mask=%h data=%h, required all 0", out_valid, out_mask, out_data);
        end
        n_vec++;
        if (out_addr !== 16'h0 || out_addr1 !== 16'hFFFF) begin
            n_err++;
            $display("FAIL reset_addr: %h/%h, required 0000/ffff", out_addr, out_addr1);
        end
        n_vec++;
        if (overflow !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: overflow=%b busy=%b, required 0/0", overflow, busy);
        end
    endtask

    task automatic test_full_line();
        logic [511:0] exp;
        exp = '0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            exp[32*i +: 32] = 32'(i + 1);
            drive(1'b1, 32'(i + 1), 1'b0, 1'b1);
            if (i == 14) begin
                n_vec++;
                if (out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_early_valid: %b, required 0", out_valid);
                end
            end
        end
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL full_latency: valid=%b, required 1", out_valid);
        end
        n_vec++;
        if (out_data !== exp) begin
            n_err++;
            $display("FAIL full_data: %h, required %h", out_data, exp);
        end
        n_vec++;
        if (out_mask !== 16'hFFFF || out_addr !== 16'h0) begin
            n_err++;
            $display("FAIL full_mask_addr: %h/%h, required ffff/0000", out_mask, out_addr);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_addr !== 16'h1) begin
            n_err++;
            $display("FAIL full_accept: valid=%b busy=%b addr=%h, required 0/0/0001", out_valid, busy, out_addr);
        end
    endtask

    task automatic test_flush();
        logic [31:0]  v[3];
        logic [511:0] exp;
        exp = '0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            v[i] = $urandom;
            exp[32*i +: 32] = relu(v[i]);
            drive(1'b1, v[i], 1'b0, 1'b0);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_mask !== 16'h0007) begin
            n_err++;
            $display("FAIL flush_mask: valid=%b mask=%h, required 1/0007", out_valid, out_mask);
        end
        n_vec++;
        if (out_data !== exp) begin
            n_err++;
            $display("FAIL flush_data: %h, required %h", out_data, exp);
        end
        drive(1'b0, '0, 1'b1, 1'b1);
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle: busy=%b valid=%b, required 0/0", busy, out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [31:0]  v[80];
        logic [511:0] exp;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            v[i] = $urandom;
            drive(1'b1, v[i], 1'b0, 1'b0);
        end
        n_vec++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_before: valid=%b busy=%b overflow=%b, required 1/1/0", out_valid, busy, overflow);
        end
        drive(1'b1, $urandom, 1'b0, 1'b0);
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: %b, required 1", overflow);
        end
        for (int k = 0; k < 5; k++) begin
            exp = '0;
            for (int i = 0; i < 16; i++) exp[32*i +: 32] = relu(v[16*k + i]);
            n_vec++;
            if (out_valid !== 1'b1 || out_addr !== 16'(k) || out_mask !== 16'hFFFF || out_data !== exp) begin
                n_err++;
                $display("FAIL ovf_drain%0d: valid=%b addr=%h mask=%h data=%h, required 1/%h/ffff/%h",
                         k, out_valid, out_addr, out_mask, out_data, 16'(k), exp);
            end
            drive(1'b0, '0, 1'b0, 1'b1);
        end
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_after: valid=%b busy=%b overflow=%b, required 0/0/1", out_valid, busy, overflow);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, $urandom, 1'b0, 1'b1);
            if (i == 15) begin
                n_vec++;
                if (out_valid1 !== 1'b1 || out_addr1 !== 16'hFFFF) begin
                    n_err++;
                    $display("FAIL wrap_first: valid=%b addr=%h, required 1/ffff", out_valid1, out_addr1);
                end
            end
        end
        n_vec++;
        if (out_valid1 !== 1'b1 || out_addr1 !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap_second: valid=%b addr=%h, required 1/0000", out_valid1, out_addr1);
        end
    endtask

    task automatic test_flush_same();
        do_reset();
        for (int i = 0; i < 16; i++) drive(1'b1, $urandom, (i == 15), 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_mask !== 16'hFFFF) begin
            n_err++;
            $display("FAIL same_line: valid=%b mask=%h, required 1/ffff", out_valid, out_mask);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL same_no_empty: valid=%b busy=%b, required 0/0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [511:0] exp;
        logic [31:0]  r;
        exp = '0;
        do_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy: %b, required 1", busy);
        end
        do_reset();
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_addr !== 16'h0) begin
            n_err++;
            $display("FAIL mid_reset: busy=%b valid=%b addr=%h, required 0/0/0000", busy, out_valid, out_addr);
        end
        for (int i = 0; i < 16; i++) begin
            r = $urandom;
            exp[32*i +: 32] = relu(r);
            drive(1'b1, r, 1'b0, 1'b0);
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_mask !== 16'hFFFF || out_addr !== 16'h0 || out_data !== exp) begin
            n_err++;
            $display("FAIL mid_clean_line: valid=%b mask=%h addr=%h data=%h, required 1/ffff/0000/%h",
                     out_valid, out_mask, out_addr, out_data, exp);
        end
    endtask

    task automatic test_relu();
        logic [31:0] lane0, lane1, exp0;
`ifdef RESULT_RELU_EN
        exp0 = 32'h0;
`else
        exp0 = 32'hFFFFFFFF;
`endif
        do_reset();
        drive(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        drive(1'b1, 32'h5, 1'b1, 1'b0);
        lane0 = out_data[31:0];
        lane1 = out_data[63:32];
        n_vec++;
        if (out_mask !== 16'h0003 || lane0 !== exp0 || lane1 !== 32'h5) begin
            n_err++;
            $display("FAIL relu_lanes: mask=%h lane0=%h lane1=%h, required 0003/%h/00000005",
                     out_mask, lane0, lane1, exp0);
        end
    endtask

    task automatic test_random();
        int pr, pv;
        bit eb;
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            pr = (ph == 0) ? 90 : (ph == 1) ? 4 : 50;
            pv = (ph == 2) ? 95 : 70;
            for (int c = 0; c < 1000; c++) begin
                drive($urandom_range(99, 0) < pv, $urandom, $urandom_range(99, 0) < 6,
                      $urandom_range(99, 0) < pr);
                eb = (m_part.size() != 0) || m_pend || (m_qd.size() != 0);
                n_vec++;
                if (out_valid !== (m_qd.size() != 0) || busy !== eb || overflow !== m_ovf) begin
                    n_err++;
                    $display("FAIL rand_flags ph%0d c%0d: valid=%b busy=%b ovf=%b, required %b/%b/%b",
                             ph, c, out_valid, busy, overflow, (m_qd.size() != 0), eb, m_ovf);
                end
                if (m_qd.size() != 0) begin
                    n_vec++;
                    if (out_data !== m_qd[0] || out_mask !== m_qm[0] || out_addr !== m_addr) begin
                        n_err++;
                        $display("FAIL rand_line ph%0d c%0d: mask=%h addr=%h data=%h, required %h/%h/%h",
                                 ph, c, out_mask, out_addr, out_data, m_qm[0], m_addr, m_qd[0]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_flush();
        test_overflow();
        test_wrap();
        test_flush_same();
        test_reset_mid();
        test_relu();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
